// File: rtl/reset_pkg.sv
// Shared types and defaults for the reset sequencer: FSM state encoding,
// reset-domain indices and the default timing of the release schedule.
package reset_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    RELEASE,
    RUN,
    REBOOT
  } rs_state_t;

  localparam int STG_HUB  = 0;
  localparam int STG_COG  = 1;
  localparam int STG_IO   = 2;
  localparam int STG_BOOT = 3;

  localparam int RS_NUM_STAGES    = STG_BOOT + 1;
  localparam int RS_LOCK_CYCLES   = 1600;  // 10 us at 160 MHz
  localparam int RS_GAP_CYCLES    = 16;
  localparam int RS_REBOOT_CYCLES = 32;

  // Counter width able to hold limit-1, never narrower than one bit.
  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit);
  endfunction

endpackage

// File: rtl/rs_pulse_stretch.sv
// Load/count-down stretcher: a single-cycle load produces an output pulse
// exactly WIDTH cycles long. Reset clears the pulse immediately.
module rs_pulse_stretch
  import reset_pkg::*;
#(
  parameter int WIDTH = RS_REBOOT_CYCLES
) (
  input  logic i_clk,
  input  logic i_srst,
  input  logic i_load,
  output logic o_pulse
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (i_load) begin
      r_cnt   <= CNT_LOAD;
      r_pulse <= 1'b1;
    end else if (r_pulse) begin
      // The load edge counts as the first high cycle, so drop after WIDTH-1 more.
      if (r_cnt == '0) begin
        r_pulse <= 1'b0;
      end else begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/reset_sequencer.sv
// Releases per-domain resets in order once the PLL has been stably locked,
// pulses boot_start at the end, and turns a software reboot into a filter reset.
module reset_sequencer
  import reset_pkg::*;
#(
  parameter int NUM_STAGES    = RS_NUM_STAGES,
  parameter int LOCK_CYCLES   = RS_LOCK_CYCLES,
  parameter int GAP_CYCLES    = RS_GAP_CYCLES,
  parameter int REBOOT_CYCLES = RS_REBOOT_CYCLES
) (
  input  logic                  clock_160,
  input  logic                  res,
  input  logic                  pll_locked,
  input  logic                  reboot_req,
  output logic [NUM_STAGES-1:0] stage_res,
  output logic                  boot_start,
  output logic                  reboot_out
);

  localparam int LOCK_W = cnt_width(LOCK_CYCLES);
  localparam int GAP_W  = cnt_width(GAP_CYCLES);
  localparam int IDX_W  = cnt_width(NUM_STAGES);

  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(NUM_STAGES - 1);

  rs_state_t             r_state, w_state_next;
  logic [LOCK_W-1:0]     r_lock_cnt, w_lock_cnt_next;
  logic [GAP_W-1:0]      r_gap_cnt, w_gap_cnt_next;
  logic [IDX_W-1:0]      r_idx, w_idx_next;
  logic [NUM_STAGES-1:0] r_stage_res, w_stage_res_next;
  logic                  r_boot_start, w_boot_start_next;
  logic                  w_reboot_load;
  logic [NUM_STAGES-1:0] w_idx_hot;

  // One-hot decode of the stage currently being released.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_STAGES; gi++) begin : g_idx_dec
      assign w_idx_hot[gi] = (r_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clock_160) begin
    if (res) begin
      r_state      <= HOLD;
      r_lock_cnt   <= '0;
      r_gap_cnt    <= '0;
      r_idx        <= '0;
      r_stage_res  <= '1;
      r_boot_start <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_lock_cnt   <= w_lock_cnt_next;
      r_gap_cnt    <= w_gap_cnt_next;
      r_idx        <= w_idx_next;
      r_stage_res  <= w_stage_res_next;
      r_boot_start <= w_boot_start_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_lock_cnt_next   = r_lock_cnt;
    w_gap_cnt_next    = r_gap_cnt;
    w_idx_next        = r_idx;
    w_stage_res_next  = r_stage_res;
    w_boot_start_next = 1'b0;
    w_reboot_load     = 1'b0;

    case (r_state)
      HOLD: begin
        w_state_next = WAIT_LOCK;
      end

      WAIT_LOCK: begin
        if (!pll_locked) begin
          w_lock_cnt_next = '0;
        end else if (r_lock_cnt == LOCK_LAST) begin
          w_state_next    = RELEASE;
          w_lock_cnt_next = '0;
          w_gap_cnt_next  = '0;
          w_idx_next      = '0;
        end else begin
          w_lock_cnt_next = r_lock_cnt + 1'b1;
        end
      end

      RELEASE: begin
        // Lock loss outranks the release step, including the final one.
        if (!pll_locked) begin
          w_state_next     = WAIT_LOCK;
          w_stage_res_next = '1;
          w_lock_cnt_next  = '0;
          w_gap_cnt_next   = '0;
          w_idx_next       = '0;
        end else if (r_gap_cnt == GAP_LAST) begin
          w_stage_res_next = r_stage_res & ~w_idx_hot;
          w_gap_cnt_next   = '0;
          if (r_idx == IDX_LAST) begin
            w_state_next      = RUN;
            w_boot_start_next = 1'b1;
          end else begin
            w_idx_next = r_idx + 1'b1;
          end
        end else begin
          w_gap_cnt_next = r_gap_cnt + 1'b1;
        end
      end

      RUN: begin
        if (!pll_locked) begin
          w_state_next     = WAIT_LOCK;
          w_stage_res_next = '1;
          w_lock_cnt_next  = '0;
          w_gap_cnt_next   = '0;
          w_idx_next       = '0;
        end else if (reboot_req) begin
          w_state_next     = REBOOT;
          w_stage_res_next = '1;
          w_reboot_load    = 1'b1;
        end
      end

      // Only the filter asserting res leaves this state.
      REBOOT: begin
        w_stage_res_next = '1;
      end

      default: begin
        w_state_next     = HOLD;
        w_stage_res_next = '1;
      end
    endcase
  end

  rs_pulse_stretch #(
    .WIDTH (REBOOT_CYCLES)
  ) u_reboot_stretch (
    .i_clk   (clock_160),
    .i_srst  (res),
    .i_load  (w_reboot_load),
    .o_pulse (reboot_out)
  );

  assign stage_res  = r_stage_res;
  assign boot_start = r_boot_start;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with a short schedule (3 stages,
// lock 8, gap 4, reboot 5); expected outputs are derived from edge counts.
module tb_reset_sequencer;
  import reset_pkg::*;

  localparam int NS = 3;
  localparam int LC = 8;
  localparam int GC = 4;
  localparam int RC = 5;
  localparam int SEQ_LEN = LC + GC * NS + 2;
  localparam logic [NS-1:0] ALL1 = '1;

  logic          clk = 1'b0;
  logic          res;
  logic          pll_locked;
  logic          reboot_req;
  logic [NS-1:0] stage_res;
  logic          boot_start;
  logic          reboot_out;

  int n_tests = 0;
  int n_fail  = 0;
  bit mon_en  = 1'b0;
  bit suffix_ok;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES    (NS),
    .LOCK_CYCLES   (LC),
    .GAP_CYCLES    (GC),
    .REBOOT_CYCLES (RC)
  ) dut (
    .clock_160  (clk),
    .res        (res),
    .pll_locked (pll_locked),
    .reboot_req (reboot_req),
    .stage_res  (stage_res),
    .boot_start (boot_start),
    .reboot_out (reboot_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [NS-1:0] exp_stage,
                            input logic exp_boot, input logic exp_reboot);
    check({tag, "_stage"}, 32'(stage_res), 32'(exp_stage));
    check({tag, "_boot"}, 32'(boot_start), 32'(exp_boot));
    check({tag, "_reboot"}, 32'(reboot_out), 32'(exp_reboot));
  endtask

  // Caller has just completed the edge that left lock_cnt at 0 in WAIT_LOCK
  // with pll_locked held high from here on. req_at pulses reboot_req so that
  // edge k samples it (-1 for none).
  task automatic expect_sequence(input string tag, input int req_at, input int last_k);
    logic [NS-1:0] exp_s;
    logic          exp_b;
    for (int k = 1; k <= last_k; k++) begin
      reboot_req = (k == req_at);
      tick();
      reboot_req = 1'b0;
      for (int j = 0; j < NS; j++) exp_s[j] = (k < LC + GC * (j + 1));
      exp_b = (k == LC + GC * NS);
      check_outs($sformatf("%s_k%0d", tag, k), exp_s, exp_b, 1'b0);
    end
    $display("[TB] %s: sequence checked through edge %0d", tag, last_k);
  endtask

  task automatic restart(input string tag);
    res = 1'b1;
    tick();
    res = 1'b0;
    tick();
    check_outs({tag, "_e0"}, ALL1, 1'b0, 1'b0);
  endtask

  // Stage i may be released only after every lower stage.
  always @(negedge clk) begin
    if (mon_en) begin
      suffix_ok = 1'b0;
      for (int c = 0; c <= NS; c++) begin
        if (stage_res == NS'(ALL1 << c)) suffix_ok = 1'b1;
      end
      check("suffix_mask", 32'(suffix_ok), 32'd1);
    end
  end

  initial begin
    res        = 1'b1;
    pll_locked = 1'b1;
    reboot_req = 1'b0;
    repeat (3) tick();
    check_outs("reset", ALL1, 1'b0, 1'b0);
    check("reset_hub", 32'(stage_res[STG_HUB]), 32'd1);
    check("reset_cog", 32'(stage_res[STG_COG]), 32'd1);
    check("reset_io", 32'(stage_res[STG_IO]), 32'd1);
    mon_en = 1'b1;
    $display("[TB] reset state checked");

    res = 1'b0;
    tick();
    check_outs("pwrup_e0", ALL1, 1'b0, 1'b0);
    expect_sequence("pwrup", -1, SEQ_LEN);

    pll_locked = 1'b0;
    tick();
    check_outs("run_loss", ALL1, 1'b0, 1'b0);
    pll_locked = 1'b1;
    expect_sequence("relock", -1, SEQ_LEN);

    reboot_req = 1'b1;
    tick();
    reboot_req = 1'b0;
    check_outs("reboot_k1", ALL1, 1'b0, 1'b1);
    for (int k = 2; k <= 19; k++) begin
      tick();
      check_outs($sformatf("reboot_k%0d", k), ALL1, 1'b0, (k <= RC) ? 1'b1 : 1'b0);
    end
    res = 1'b1;
    tick();
    check_outs("reboot_res", ALL1, 1'b0, 1'b0);
    res = 1'b0;
    tick();
    check_outs("reboot_e0", ALL1, 1'b0, 1'b0);
    expect_sequence("after_reboot", -1, SEQ_LEN);

    pll_locked = 1'b0;
    reboot_req = 1'b1;
    tick();
    reboot_req = 1'b0;
    check_outs("coinc", ALL1, 1'b0, 1'b0);
    pll_locked = 1'b1;
    expect_sequence("coinc_relock", -1, SEQ_LEN);

    restart("glitch");
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_outs($sformatf("glitch_k%0d", k), ALL1, 1'b0, 1'b0);
    end
    pll_locked = 1'b0;
    tick();
    check_outs("glitch_e5", ALL1, 1'b0, 1'b0);
    pll_locked = 1'b1;
    expect_sequence("glitch", 3, SEQ_LEN);

    restart("req_rel");
    expect_sequence("req_release", 14, SEQ_LEN);

    restart("final");
    expect_sequence("pre_final", -1, LC + GC * NS - 1);
    pll_locked = 1'b0;
    tick();
    check_outs("final_loss", ALL1, 1'b0, 1'b0);
    pll_locked = 1'b1;
    expect_sequence("after_final", -1, SEQ_LEN);

    reboot_req = 1'b1;
    tick();
    reboot_req = 1'b0;
    check_outs("midrb_k1", ALL1, 1'b0, 1'b1);
    res = 1'b1;
    tick();
    check_outs("midrb_res", ALL1, 1'b0, 1'b0);
    tick();
    check_outs("midrb_hold", ALL1, 1'b0, 1'b0);
    res = 1'b0;
    tick();
    check_outs("midrb_e0", ALL1, 1'b0, 1'b0);
    expect_sequence("midrb_restart", -1, SEQ_LEN);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
